pifo_sram_radix: RTL and testbench
==================================

PIFO_SRAM_RADIX -- requirements
Module: pifo_sram_radix

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): PTW, 16, priority/payload width; MTW, 0, metadata width; CTW, 10, sub-tree counter width; RADIX, 4, children per node (power of 2, >=2); LEVEL, 4, tree depth; TREE_NUM, 4, trees sharing the SRAM; ADW, 8, node address width within a level.
REQ-002 Derived widths SHALL be: DW=MTW+PTW; EW=CTW+DW (one entry); RB=log2(RADIX); LB=log2(LEVEL); TB=log2(TREE_NUM); SAW=TB+ADW.
REQ-003 Ports (name direction width meaning), clock and reset first:
- i_clk in 1 clock; i_arst_n in 1 reset, asynchronous, active-low.
- i_push in 1 push from parent; i_push_data in DW push data; i_pop in 1 pop from parent; o_pop_data out DW popped data; o_ready out 1 node accepts a command this cycle.
- i_tree_id in TB; i_my_addr in ADW; i_level in LB: command context.
- o_push out 1, o_push_data out DW, o_pop out 1, i_pop_data in DW: child interface.
- o_tree_id out TB, o_child_addr out ADW, o_level out LB: child context.
- o_read out 1, o_read_addr out SAW, i_read_data in RADIX*EW; o_write out 1, o_write_addr out SAW, o_write_data out RADIX*EW: SRAM port; entry k at bits [(k+1)*EW-1 : k*EW] as {count, data}.
- o_overflow out 1 push dropped (counter saturated); o_cmd_err out 1 illegal simultaneous push+pop.

Function
REQ-004 States SHALL be IDLE, PUSH, POP, WB; o_ready=1 in IDLE, PUSH, WB; o_ready=0 in POP.
REQ-005 From a ready state: i_push only -> PUSH; i_pop only -> POP; neither -> IDLE; both -> IDLE, command ignored, o_cmd_err=1 for that cycle; POP -> WB unconditionally; commands in POP ignored.
REQ-006 On an accepted command: o_read=1, o_read_addr={i_tree_id,i_my_addr} same cycle; latch tree_id, my_addr, level, push data; SRAM data valid on i_read_data the following cycle.
REQ-007 An entry with data[PTW-1:0] all ones SHALL be treated as empty.
REQ-008 PUSH: select port p = entry with minimum count, lowest index on tie; if count[p] is all ones, no write, no child push, o_overflow=1 one cycle.
REQ-009 PUSH, not saturated: o_write=1 at {tree,my_addr}; count[p]+1; if entry p empty, store pushed data, no child push; else keep smaller priority (strict <, pushed wins only if strictly smaller) and o_push=1 with larger one on o_push_data; other entries unchanged.
REQ-010 POP: select port p = minimum priority, lowest index on tie; o_pop_data=data[p] this cycle; latch whole read word; o_pop=1 to child iff count[p]!=0; if all entries empty, o_pop_data all ones and no write in WB.
REQ-011 WB: o_write=1 with latched word where entry p gets count[p]-1 and data i_pop_data if count[p]!=0, else data all ones; other entries unchanged.
REQ-012 o_child_addr SHALL be my_addr*RADIX+p (truncated to ADW) whenever o_push or o_pop is 1, else all ones; o_level=level+1; o_tree_id=latched tree_id.
REQ-013 When latched level==LEVEL-1, o_push and o_pop SHALL be forced 0; SRAM update still performed.
REQ-014 Counter arithmetic SHALL be modulo-free: increment never exceeds all ones (REQ-008), decrement occurs only when count!=0.
REQ-015 Outside PUSH/POP/WB: o_write=0, o_push=0, o_pop=0, o_push_data=0, o_write_data=0, o_pop_data all ones.

Reset
REQ-016 On i_arst_n low, asynchronously: state IDLE, all latches 0, o_read/o_write/o_push/o_pop/o_overflow/o_cmd_err=0, o_pop_data all ones; reset mid-POP/WB aborts with no SRAM write.
REQ-017 After release, first command accepted on the next rising edge.

Verification
REQ-018 RADIX=4, push 0x0010 to node with all entries empty, counts 0 -> write entry 0 = {1,0x0010}, o_push=0.
REQ-019 Counts {2,1,1,3}, entry1 data 0x0005, push 0x0003 -> entry1 = {2,0x0003}, o_push=1, o_push_data=0x0005, o_child_addr=my_addr*4+1.
REQ-020 Data {0x9,0x4,0x4,0x7}, counts {0,2,1,0}, pop -> o_pop_data=0x4 (port1), o_pop=1; WB writes entry1 = {1,i_pop_data}.
REQ-021 Pop at level LEVEL-1 with count 0 -> o_pop=0, WB writes entry p data all ones, count 0.
REQ-022 Push to port whose minimum count is all ones -> o_overflow=1, o_write=0; i_push&i_pop in IDLE -> o_cmd_err=1, state stays IDLE.
REQ-023 Reset asserted in POP state -> no write next cycle, all outputs at REQ-016 values.

Source files
------------

// File: rtl/pifo_sram_radix_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pifo_sram_radix_if
// Brief    : Bundle of parent-command, child-command and SRAM signals of one
//            radix PIFO tree node.
// Revision : 1.0 - initial release
// ============================================================================
interface pifo_sram_radix_if #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int CTW      = 10,
  parameter int RADIX    = 4,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int ADW      = 8
);
  localparam int DW  = MTW + PTW;
  localparam int EW  = CTW + DW;
  localparam int LB  = $clog2(LEVEL);
  localparam int TB  = $clog2(TREE_NUM);
  localparam int SAW = TB + ADW;

  // parent side
  logic                  i_push;
  logic [DW-1:0]         i_push_data;
  logic                  i_pop;
  logic [DW-1:0]         o_pop_data;
  logic                  o_ready;
  logic [TB-1:0]         i_tree_id;
  logic [ADW-1:0]        i_my_addr;
  logic [LB-1:0]         i_level;
  // child side
  logic                  o_push;
  logic [DW-1:0]         o_push_data;
  logic                  o_pop;
  logic [DW-1:0]         i_pop_data;
  logic [TB-1:0]         o_tree_id;
  logic [ADW-1:0]        o_child_addr;
  logic [LB-1:0]         o_level;
  // SRAM side
  logic                  o_read;
  logic [SAW-1:0]        o_read_addr;
  logic [RADIX*EW-1:0]   i_read_data;
  logic                  o_write;
  logic [SAW-1:0]        o_write_addr;
  logic [RADIX*EW-1:0]   o_write_data;
  // status
  logic                  o_overflow;
  logic                  o_cmd_err;

  // node view
  modport slave (
    input  i_push, i_push_data, i_pop, i_tree_id, i_my_addr, i_level,
           i_pop_data, i_read_data,
    output o_pop_data, o_ready, o_push, o_push_data, o_pop, o_tree_id,
           o_child_addr, o_level, o_read, o_read_addr, o_write, o_write_addr,
           o_write_data, o_overflow, o_cmd_err
  );

  // environment view (parent, child and SRAM together)
  modport master (
    output i_push, i_push_data, i_pop, i_tree_id, i_my_addr, i_level,
           i_pop_data, i_read_data,
    input  o_pop_data, o_ready, o_push, o_push_data, o_pop, o_tree_id,
           o_child_addr, o_level, o_read, o_read_addr, o_write, o_write_addr,
           o_write_data, o_overflow, o_cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/pifo_sram_radix.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : pifo_sram_radix
// Brief    : One node of an SRAM-backed radix PIFO tree. Each SRAM word holds
//            RADIX {subtree count, data} entries; pushes go to the lightest
//            subtree, pops take the smallest priority and refill from the child.
// Revision : 1.0 - initial release
// ============================================================================
module pifo_sram_radix #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int CTW      = 10,
  parameter int RADIX    = 4,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int ADW      = 8
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  pifo_sram_radix_if.slave bus
);
  localparam int DW  = MTW + PTW;
  localparam int EW  = CTW + DW;
  localparam int RB  = $clog2(RADIX);
  localparam int LB  = $clog2(LEVEL);
  localparam int TB  = $clog2(TREE_NUM);
  localparam int SAW = TB + ADW;
  localparam int WW  = RADIX * EW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TB-1:0]   tree_q, tree_d;
  logic [ADW-1:0]  addr_q, addr_d;
  logic [LB-1:0]   level_q, level_d;
  logic [DW-1:0]   pdata_q, pdata_d;
  logic [WW-1:0]   word_q, word_d;
  logic [RB-1:0]   port_q, port_d;
  logic            empty_q, empty_d;

  logic [CTW-1:0]  rd_cnt [RADIX];
  logic [DW-1:0]   rd_dat [RADIX];
  logic [RB-1:0]   cnt_p, pri_p, child_p;
  logic [CTW-1:0]  cnt_min, wb_cnt;
  logic [PTW-1:0]  pri_min;
  logic            all_empty, last, ready;
  logic            read, write, push, pop, overflow, cmd_err;
  logic [SAW-1:0]  read_addr, write_addr;
  logic [WW-1:0]   wr_word;
  logic [DW-1:0]   fwd, pop_data;
  logic [ADW+RB-1:0] child_full;

  assign ready      = (state_q != S_POP);
  assign last       = (level_q == LB'(LEVEL - 1));
  assign write_addr = {tree_q, addr_q};
  assign child_full = {addr_q, child_p};

  // Split the SRAM word into per-child counters and data
  always_comb begin
    for (int k = 0; k < RADIX; k++) begin
      rd_cnt[k] = bus.i_read_data[k*EW+DW +: CTW];
      rd_dat[k] = bus.i_read_data[k*EW +: DW];
    end
  end

  // Push target is the lightest subtree, pop target the smallest priority;
  // strict compares keep the lowest index on ties
  always_comb begin
    cnt_p   = '0;
    cnt_min = rd_cnt[0];
    pri_p   = '0;
    pri_min = rd_dat[0][PTW-1:0];
    for (int k = 1; k < RADIX; k++) begin
      if (rd_cnt[k] < cnt_min) begin
        cnt_min = rd_cnt[k];
        cnt_p   = RB'(k);
      end
      if (rd_dat[k][PTW-1:0] < pri_min) begin
        pri_min = rd_dat[k][PTW-1:0];
        pri_p   = RB'(k);
      end
    end
    // an all-ones priority marks an empty slot, so the minimum is all ones
    // only when every slot is empty
    all_empty = (pri_min == '1);
  end

  // Command acceptance, next state and per-state datapath
  always_comb begin
    state_d   = state_q;
    tree_d    = tree_q;
    addr_d    = addr_q;
    level_d   = level_q;
    pdata_d   = pdata_q;
    word_d    = word_q;
    port_d    = port_q;
    empty_d   = empty_q;
    read      = 1'b0;
    read_addr = '0;
    cmd_err   = 1'b0;
    write     = 1'b0;
    wr_word   = bus.i_read_data;
    push      = 1'b0;
    fwd       = '0;
    pop       = 1'b0;
    pop_data  = '1;
    overflow  = 1'b0;
    child_p   = '0;
    wb_cnt    = '0;

    // gate with reset so nothing leaks onto the SRAM port while held
    if (ready && i_arst_n) begin
      if (bus.i_push ^ bus.i_pop) begin
        read      = 1'b1;
        read_addr = {bus.i_tree_id, bus.i_my_addr};
        tree_d    = bus.i_tree_id;
        addr_d    = bus.i_my_addr;
        level_d   = bus.i_level;
        pdata_d   = bus.i_push_data;
        state_d   = bus.i_push ? S_PUSH : S_POP;
      end else begin
        cmd_err = bus.i_push & bus.i_pop;
        state_d = S_IDLE;
      end
    end

    unique case (state_q)
      S_PUSH: begin
        child_p = cnt_p;
        if (cnt_min == '1) begin
          overflow = 1'b1;
        end else begin
          write = 1'b1;
          wr_word[int'(cnt_p)*EW+DW +: CTW] = cnt_min + CTW'(1);
          if (rd_dat[cnt_p][PTW-1:0] == '1) begin
            wr_word[int'(cnt_p)*EW +: DW] = pdata_q;
          end else begin
            // the larger of the two sinks into the subtree
            push = ~last;
            if (pdata_q[PTW-1:0] < rd_dat[cnt_p][PTW-1:0]) begin
              wr_word[int'(cnt_p)*EW +: DW] = pdata_q;
              fwd = rd_dat[cnt_p];
            end else begin
              fwd = pdata_q;
            end
          end
        end
      end
      S_POP: begin
        state_d  = S_WB;
        child_p  = pri_p;
        pop_data = all_empty ? '1 : rd_dat[pri_p];
        pop      = (rd_cnt[pri_p] != '0) && !last;
        word_d   = bus.i_read_data;
        port_d   = pri_p;
        empty_d  = all_empty;
      end
      S_WB: begin
        if (!empty_q) begin
          write   = 1'b1;
          wr_word = word_q;
          wb_cnt  = word_q[int'(port_q)*EW+DW +: CTW];
          if (wb_cnt != '0) begin
            wr_word[int'(port_q)*EW+DW +: CTW] = wb_cnt - CTW'(1);
            wr_word[int'(port_q)*EW +: DW]     = bus.i_pop_data;
          end else begin
            wr_word[int'(port_q)*EW +: DW] = '1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and latched command context
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
      tree_q  <= '0;
      addr_q  <= '0;
      level_q <= '0;
      pdata_q <= '0;
      word_q  <= '0;
      port_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tree_q  <= tree_d;
      addr_q  <= addr_d;
      level_q <= level_d;
      pdata_q <= pdata_d;
      word_q  <= word_d;
      port_q  <= port_d;
      empty_q <= empty_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_cmd_err    = cmd_err;
  assign bus.o_read       = read;
  assign bus.o_read_addr  = read_addr;
  assign bus.o_write      = write;
  assign bus.o_write_addr = write_addr;
  assign bus.o_write_data = write ? wr_word : '0;
  assign bus.o_push       = push;
  assign bus.o_push_data  = push ? fwd : '0;
  assign bus.o_pop        = pop;
  assign bus.o_pop_data   = pop_data;
  assign bus.o_overflow   = overflow;
  assign bus.o_tree_id    = tree_q;
  assign bus.o_level      = level_q + LB'(1);
  assign bus.o_child_addr = (push | pop) ? child_full[ADW-1:0] : '1;
endmodule
`default_nettype wire

// File: tb/tb_pifo_sram_radix.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pifo_sram_radix
// Brief    : Self-checking bench for pifo_sram_radix; the bench plays parent,
//            child and SRAM, and predicts every output from the node rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_sram_radix;
  localparam int EW = 26;
  localparam int WW = 4 * EW;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pifo_sram_radix_if #(.PTW(16), .MTW(0), .CTW(10), .RADIX(4), .LEVEL(4),
                       .TREE_NUM(4), .ADW(8)) bus ();

  pifo_sram_radix #(.PTW(16), .MTW(0), .CTW(10), .RADIX(4), .LEVEL(4),
                    .TREE_NUM(4), .ADW(8)) dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ecnt(input logic [WW-1:0] w, input int k);
    return w[k*EW+16 +: 10];
  endfunction

  function automatic logic [15:0] edat(input logic [WW-1:0] w, input int k);
    return w[k*EW +: 16];
  endfunction

  function automatic logic [WW-1:0] put(input logic [WW-1:0] w, input int k,
                                        input logic [9:0] c, input logic [15:0] d);
    logic [WW-1:0] r;
    r = w;
    r[k*EW +: EW] = {c, d};
    return r;
  endfunction

  function automatic logic [WW-1:0] gen_word();
    logic [WW-1:0] w;
    logic [9:0]    c;
    logic [15:0]   d;
    int            s;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      s = int'($urandom_range(0, 7));
      c = (s == 7) ? 10'h3ff : (s == 6) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 3));
      s = int'($urandom_range(0, 4));
      d = (s == 0) ? 16'hffff : (s == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      w = put(w, k, c, d);
    end
    return w;
  endfunction

  // push command, then SRAM answer; checks the whole update cycle
  task automatic do_push(input logic [1:0] tr, input logic [7:0] ad, input logic [1:0] lv,
                         input logic [15:0] pd, input logic [WW-1:0] w);
    int            p;
    logic [9:0]    mn;
    logic [15:0]   keep, fwd;
    logic          fwd_v, sat, exp_push;
    logic [WW-1:0] ew;
    logic [7:0]    ca;
    mn = 10'h3ff;
    for (int k = 0; k < 4; k++) if (ecnt(w, k) < mn) mn = ecnt(w, k);
    p = 0;
    for (int k = 3; k >= 0; k--) if (ecnt(w, k) == mn) p = k;
    sat   = (mn == 10'h3ff);
    ew    = w;
    fwd   = '0;
    fwd_v = 1'b0;
    if (!sat) begin
      if (edat(w, p) == 16'hffff) begin
        keep = pd;
      end else begin
        fwd_v = 1'b1;
        keep  = (pd < edat(w, p)) ? pd : edat(w, p);
        fwd   = (pd < edat(w, p)) ? edat(w, p) : pd;
      end
      ew = put(w, p, mn + 10'd1, keep);
    end
    exp_push = fwd_v && (lv != 2'd3);
    ca = exp_push ? 8'((int'(ad) * 4 + p) % 256) : 8'hff;

    @(negedge clk);
    bus.i_push = 1'b1; bus.i_push_data = pd;
    bus.i_tree_id = tr; bus.i_my_addr = ad; bus.i_level = lv;
    #1;
    chk("push_read", 128'(bus.o_read), 128'(1'b1));
    chk("push_read_addr", 128'(bus.o_read_addr), 128'({tr, ad}));
    @(negedge clk);
    bus.i_push = 1'b0; bus.i_read_data = w;
    bus.i_tree_id = ~tr; bus.i_my_addr = ~ad; bus.i_level = ~lv;
    #1;
    chk("push_write", 128'(bus.o_write), 128'(!sat));
    chk("push_write_addr", 128'(bus.o_write_addr), 128'({tr, ad}));
    chk("push_write_data", 128'(bus.o_write_data), sat ? 128'(0) : 128'(ew));
    chk("push_overflow", 128'(bus.o_overflow), 128'(sat));
    chk("push_child_push", 128'(bus.o_push), 128'(exp_push));
    chk("push_child_data", 128'(bus.o_push_data), exp_push ? 128'(fwd) : 128'(0));
    chk("push_child_addr", 128'(bus.o_child_addr), 128'(ca));
    chk("push_level", 128'(bus.o_level), 128'(2'(lv + 2'd1)));
    chk("push_tree", 128'(bus.o_tree_id), 128'(tr));
  endtask

  // pop command, SRAM answer, then child answer during write-back
  task automatic do_pop(input logic [1:0] tr, input logic [7:0] ad, input logic [1:0] lv,
                        input logic [WW-1:0] w, input logic [15:0] popd);
    int            p;
    logic [15:0]   mn;
    logic          alle, exp_pop;
    logic [WW-1:0] ew;
    logic [7:0]    ca;
    mn = 16'hffff;
    for (int k = 0; k < 4; k++) if (edat(w, k) < mn) mn = edat(w, k);
    p = 0;
    for (int k = 3; k >= 0; k--) if (edat(w, k) == mn) p = k;
    alle    = (mn == 16'hffff);
    exp_pop = (ecnt(w, p) != 10'd0) && (lv != 2'd3);
    ca      = exp_pop ? 8'((int'(ad) * 4 + p) % 256) : 8'hff;
    if (ecnt(w, p) != 10'd0) ew = put(w, p, ecnt(w, p) - 10'd1, popd);
    else                     ew = put(w, p, 10'd0, 16'hffff);

    @(negedge clk);
    bus.i_pop = 1'b1;
    bus.i_tree_id = tr; bus.i_my_addr = ad; bus.i_level = lv;
    #1;
    chk("pop_read", 128'(bus.o_read), 128'(1'b1));
    chk("pop_read_addr", 128'(bus.o_read_addr), 128'({tr, ad}));
    @(negedge clk);
    bus.i_pop = 1'b0; bus.i_read_data = w;
    #1;
    chk("pop_ready", 128'(bus.o_ready), 128'(1'b0));
    chk("pop_data", 128'(bus.o_pop_data), alle ? 128'(16'hffff) : 128'(edat(w, p)));
    chk("pop_child_pop", 128'(bus.o_pop), 128'(exp_pop));
    chk("pop_child_addr", 128'(bus.o_child_addr), 128'(ca));
    chk("pop_no_write", 128'(bus.o_write), 128'(1'b0));
    @(negedge clk);
    bus.i_pop_data = popd;
    bus.i_read_data = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("wb_write", 128'(bus.o_write), 128'(!alle));
    chk("wb_write_addr", 128'(bus.o_write_addr), 128'({tr, ad}));
    chk("wb_write_data", 128'(bus.o_write_data), alle ? 128'(0) : 128'(ew));
    chk("wb_ready", 128'(bus.o_ready), 128'(1'b1));
  endtask

  initial begin
    logic [WW-1:0] w;
    rst_n = 1'b0;
    bus.i_push = 1'b0; bus.i_pop = 1'b0; bus.i_push_data = '0;
    bus.i_tree_id = '0; bus.i_my_addr = '0; bus.i_level = '0;
    bus.i_pop_data = '0; bus.i_read_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 128'(bus.o_ready), 128'(1'b1));
    chk("rst_read", 128'(bus.o_read), 128'(1'b0));
    chk("rst_write", 128'(bus.o_write), 128'(1'b0));
    chk("rst_push", 128'(bus.o_push), 128'(1'b0));
    chk("rst_pop", 128'(bus.o_pop), 128'(1'b0));
    chk("rst_pop_data", 128'(bus.o_pop_data), 128'(16'hffff));
    chk("rst_overflow", 128'(bus.o_overflow), 128'(1'b0));
    chk("rst_cmd_err", 128'(bus.o_cmd_err), 128'(1'b0));
    chk("rst_write_data", 128'(bus.o_write_data), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // push into an empty node
    w = '0;
    for (int k = 0; k < 4; k++) w = put(w, k, 10'd0, 16'hffff);
    do_push(2'd1, 8'h05, 2'd0, 16'h0010, w);

    // push displaces a larger entry into the child
    w = '0;
    w = put(w, 0, 10'd2, 16'h0001);
    w = put(w, 1, 10'd1, 16'h0005);
    w = put(w, 2, 10'd1, 16'h0009);
    w = put(w, 3, 10'd3, 16'h0002);
    do_push(2'd2, 8'h10, 2'd1, 16'h0003, w);

    // pop with a priority tie and a refill from the child
    w = '0;
    w = put(w, 0, 10'd0, 16'h0009);
    w = put(w, 1, 10'd2, 16'h0004);
    w = put(w, 2, 10'd1, 16'h0004);
    w = put(w, 3, 10'd0, 16'h0007);
    do_pop(2'd3, 8'h22, 2'd1, w, 16'h0033);

    // pop at the leaf level with an empty subtree
    w = '0;
    w = put(w, 0, 10'd0, 16'h0020);
    w = put(w, 1, 10'd0, 16'h0030);
    w = put(w, 2, 10'd0, 16'hffff);
    w = put(w, 3, 10'd0, 16'hffff);
    do_pop(2'd0, 8'h40, 2'd3, w, 16'h1234);

    // pop from a fully empty node
    w = '0;
    for (int k = 0; k < 4; k++) w = put(w, k, 10'd0, 16'hffff);
    do_pop(2'd1, 8'h41, 2'd2, w, 16'h5555);

    // push into a saturated node
    w = '0;
    for (int k = 0; k < 4; k++) w = put(w, k, 10'h3ff, 16'(16'h0100 + k));
    do_push(2'd2, 8'h77, 2'd0, 16'h0001, w);

    // simultaneous push and pop is rejected and the node stays idle
    @(negedge clk);
    bus.i_push = 1'b1; bus.i_pop = 1'b1;
    #1;
    chk("cmd_err", 128'(bus.o_cmd_err), 128'(1'b1));
    chk("cmd_err_no_read", 128'(bus.o_read), 128'(1'b0));
    @(negedge clk);
    bus.i_push = 1'b0; bus.i_pop = 1'b0;
    w = '0;
    for (int k = 0; k < 4; k++) w = put(w, k, 10'd0, 16'hffff);
    bus.i_read_data = w;
    #1;
    chk("cmd_err_clear", 128'(bus.o_cmd_err), 128'(1'b0));
    chk("cmd_err_idle_write", 128'(bus.o_write), 128'(1'b0));
    chk("cmd_err_idle_ready", 128'(bus.o_ready), 128'(1'b1));

    // reset while in the pop state aborts the write-back
    @(negedge clk);
    bus.i_pop = 1'b1; bus.i_tree_id = 2'd1; bus.i_my_addr = 8'h09; bus.i_level = 2'd0;
    @(negedge clk);
    bus.i_pop = 1'b0;
    w = '0;
    for (int k = 0; k < 4; k++) w = put(w, k, 10'd2, 16'(16'h0040 + k));
    bus.i_read_data = w;
    #1;
    chk("abort_pre_pop", 128'(bus.o_pop), 128'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_write", 128'(bus.o_write), 128'(1'b0));
    chk("abort_pop", 128'(bus.o_pop), 128'(1'b0));
    chk("abort_pop_data", 128'(bus.o_pop_data), 128'(16'hffff));
    chk("abort_ready", 128'(bus.o_ready), 128'(1'b1));
    @(negedge clk);
    bus.i_pop_data = 16'h0abc;
    #1;
    chk("abort_no_wb", 128'(bus.o_write), 128'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release_idle", 128'(bus.o_write), 128'(1'b0));

    // randomized traffic against the reference rules
    for (int i = 0; i < 200; i++) begin
      w = gen_word();
      if ($urandom_range(0, 1) == 0)
        do_push(2'($urandom), 8'($urandom), 2'($urandom), 16'($urandom_range(0, 16'hfffe)), w);
      else
        do_pop(2'($urandom), 8'($urandom), 2'($urandom), w, 16'($urandom));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
